control_unit: RTL
=================

Name: control_unit

Overview:
- Multi-cycle hardwired control FSM sitting directly upstream of the CPU datapath.
- Drives every datapath strobe: register-select, bus-driver, register-load, memory and ALU-select.
- Sequences fetch, then a per-opcode execute sequence, using the IR contents and the CON FF result fed back from the datapath.
- One microstep per clock; every datapath register loads on the rising edge that ends the step in which its _in strobe is high.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ASELW, 4, ALU_select width.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- IR  in  32  instruction register contents from datapath.
- CON_FF  in  1  branch-condition flip-flop output.
- stop  in  1  external stop request.
- run  out  1  high while executing.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select/encode controls.
- PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout  out  1 each  bus drivers.
- PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, outPort_in, CON_in  out  1 each  register loads.
- read, write  out  1 each  memory strobes.
- ALU_select  out  ASELW  ALU operation.

Behaviour:
- State register is updated asynchronously by clr. Outputs are combinational decodes of state and IR[31:27].
- Reset:
  - clr high forces state S_RST; all outputs are 0, including run.
  - The first rising edge with clr low moves to T0.
  - clr mid-instruction aborts immediately; no partial-step strobes are emitted.
- run = 1 in every state except S_RST and S_HALT.
- Unlisted strobes are 0 in every step; ALU_select defaults to ADD.
- Fetch (all opcodes):
  - T0: PCout, MAR_in, Inc_PC.
  - T1: read, MDR_in.
  - T2: MDRout, IR_in.
  - Opcode is decoded in T3 and beyond from the IR input, which is stable after T2.
- R-ALU (add, sub, and, or, shr, shra, shl, ror, rol):
  - T3: Grb, Rout, Y_in.
  - T4: Grc, Rout, ALU_select=op, Z_in.
  - T5: ZLOWout, Gra, Rin.
- I-ALU (addi, andi, ori): as R-ALU, but T4 uses Cout in place of Grc/Rout.
- neg, not:
  - T3: Grb, Rout, ALU_select=op, Z_in.
  - T4: ZLOWout, Gra, Rin.
- mul, div:
  - T3: Gra, Rout, Y_in.
  - T4: Grb, Rout, ALU_select=op, Z_in.
  - T5: ZLOWout, LO_in.
  - T6: ZHIout, HI_in.
- ld:
  - T3: Grb, BAout, Y_in.
  - T4: Cout, ADD, Z_in.
  - T5: ZLOWout, MAR_in.
  - T6: read, MDR_in.
  - T7: MDRout, Gra, Rin.
- ldi: T3–T4 as ld; T5: ZLOWout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDR_in (read=0).
  - T7: write.
- br:
  - T3: Gra, Rout, CON_in.
  - T4: PCout, Y_in.
  - T5: Cout, ADD, Z_in.
  - T6: ZLOWout, and PC_in only if CON_FF=1.
  - CON_FF is sampled in T6 only.
- Single-step opcodes (T3 only):
  - jr: Gra, Rout, PC_in.
  - in: inPortout, Gra, Rin.
  - out: Gra, Rout, outPort_in.
  - mfhi: HIout, Gra, Rin.
  - mflo: LOout, Gra, Rin.
- nop and undefined opcodes: T3 asserts nothing, then return to T0.
- halt: T3 → S_HALT. S_HALT holds with all outputs 0 until clr.
- After the last step of any sequence, the next state is T0.
- stop:
  - stop is latched (sticky) when high on any edge.
  - At the last step of the current instruction, the FSM enters S_HALT instead of T0.
  - The current instruction always completes.
  - The latch clears only on clr.
- Latency: 3 fetch cycles plus 1–5 execute cycles. No bus conflict: exactly one bus driver or none per step.

Decomposition:
- Package cpu_pkg holds:
  - Opcode constants: ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, shr=7, shra=8, shl=9, ror=10, rol=11, addi=12, andi=13, ori=14, mul=15, div=16, neg=17, not=18, br=19, jr=20, in=22, out=23, mfhi=24, mflo=25, nop=26, halt=27.
  - ALU_select codes: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, MUL=9, DIV=10, NEG=11, NOT=12.
  - State enum: S_RST, T0..T7, S_HALT.
- One sub-module is natural: op_to_alusel, a combinational opcode→ALU_select map.

Test Plan:
- Reset and fetch: clr pulse, then release → 1 cycle with all outputs 0, then T0 {PCout, MAR_in, Inc_PC}, T1 {read, MDR_in}, T2 {MDRout, IR_in}; run=1 from T0.
- add r1,r2,r3: IR=0x18918000 → T3 {Grb, Rout, Y_in}; T4 {Grc, Rout, Z_in, ALU_select=0}; T5 {ZLOWout, Gra, Rin}; T0 follows.
- ld r2,0x65(r0): IR=0x01000065 → T3–T7 exactly as specified; read high only in T1 and T6; 8 cycles total.
- brzr r5,5: IR=0x9A800005 with CON_FF=0 → T6 has ZLOWout, PC_in=0; repeat with CON_FF=1 → PC_in=1 in T6.
- mul r3,r4: IR=0x79A00000 → ALU_select=9 in T4; LO_in in T5; HI_in in T6. Assert clr during T5 → all outputs 0 immediately; resumes at T0.
- stop asserted during T4 of add → T5 completes, then S_HALT with run=0. halt IR=0xD8000000 → S_HALT after T3; outputs stay 0 for 20 cycles until clr.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: widths, opcode and
// ALU-select encodings, the microstep state type and opcode-class helpers.
package cpu_pkg;

   localparam int OPW   = 5;   // opcode field width, IR[31:27]
   localparam int ASELW = 4;   // ALU_select width

   // Opcodes
   localparam logic [OPW-1:0] OP_LD   = 5'd0;
   localparam logic [OPW-1:0] OP_LDI  = 5'd1;
   localparam logic [OPW-1:0] OP_ST   = 5'd2;
   localparam logic [OPW-1:0] OP_ADD  = 5'd3;
   localparam logic [OPW-1:0] OP_SUB  = 5'd4;
   localparam logic [OPW-1:0] OP_AND  = 5'd5;
   localparam logic [OPW-1:0] OP_OR   = 5'd6;
   localparam logic [OPW-1:0] OP_SHR  = 5'd7;
   localparam logic [OPW-1:0] OP_SHRA = 5'd8;
   localparam logic [OPW-1:0] OP_SHL  = 5'd9;
   localparam logic [OPW-1:0] OP_ROR  = 5'd10;
   localparam logic [OPW-1:0] OP_ROL  = 5'd11;
   localparam logic [OPW-1:0] OP_ADDI = 5'd12;
   localparam logic [OPW-1:0] OP_ANDI = 5'd13;
   localparam logic [OPW-1:0] OP_ORI  = 5'd14;
   localparam logic [OPW-1:0] OP_MUL  = 5'd15;
   localparam logic [OPW-1:0] OP_DIV  = 5'd16;
   localparam logic [OPW-1:0] OP_NEG  = 5'd17;
   localparam logic [OPW-1:0] OP_NOT  = 5'd18;
   localparam logic [OPW-1:0] OP_BR   = 5'd19;
   localparam logic [OPW-1:0] OP_JR   = 5'd20;
   localparam logic [OPW-1:0] OP_IN   = 5'd22;
   localparam logic [OPW-1:0] OP_OUT  = 5'd23;
   localparam logic [OPW-1:0] OP_MFHI = 5'd24;
   localparam logic [OPW-1:0] OP_MFLO = 5'd25;
   localparam logic [OPW-1:0] OP_NOP  = 5'd26;
   localparam logic [OPW-1:0] OP_HALT = 5'd27;

   // ALU operation codes
   localparam logic [ASELW-1:0] ALU_ADD  = 4'd0;
   localparam logic [ASELW-1:0] ALU_SUB  = 4'd1;
   localparam logic [ASELW-1:0] ALU_AND  = 4'd2;
   localparam logic [ASELW-1:0] ALU_OR   = 4'd3;
   localparam logic [ASELW-1:0] ALU_SHR  = 4'd4;
   localparam logic [ASELW-1:0] ALU_SHRA = 4'd5;
   localparam logic [ASELW-1:0] ALU_SHL  = 4'd6;
   localparam logic [ASELW-1:0] ALU_ROR  = 4'd7;
   localparam logic [ASELW-1:0] ALU_ROL  = 4'd8;
   localparam logic [ASELW-1:0] ALU_MUL  = 4'd9;
   localparam logic [ASELW-1:0] ALU_DIV  = 4'd10;
   localparam logic [ASELW-1:0] ALU_NEG  = 4'd11;
   localparam logic [ASELW-1:0] ALU_NOT  = 4'd12;

   // Microstep states
   typedef enum logic [3:0] {
      S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
   } state_t;

   // One-bit strobes decoded per microstep (ALU_select is carried separately)
   typedef struct packed {
      logic run;
      logic gra, grb, grc, rin, rout, ba_out;
      logic pc_out, zlow_out, zhi_out, lo_out, hi_out, mdr_out, in_port_out, c_out;
      logic pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, out_port_in, con_in;
      logic read, write;
   } ctrl_t;

   // Register-register ALU ops: three execute steps through Y and Z
   function automatic logic is_ralu(input logic [OPW-1:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
                        OP_SHL, OP_ROR, OP_ROL};
   endfunction

   // Immediate ALU ops: second operand comes from the C field
   function automatic logic is_ialu(input logic [OPW-1:0] op);
      return op inside {OP_ADDI, OP_ANDI, OP_ORI};
   endfunction

   // Single-operand ALU ops
   function automatic logic is_unary(input logic [OPW-1:0] op);
      return op inside {OP_NEG, OP_NOT};
   endfunction

   // Ops producing a 64-bit result split across LO and HI
   function automatic logic is_muldiv(input logic [OPW-1:0] op);
      return op inside {OP_MUL, OP_DIV};
   endfunction

   // Final microstep of each opcode's execute sequence; everything not
   // listed (single-step ops, nop, halt, undefined) finishes in T3.
   function automatic state_t last_step(input logic [OPW-1:0] op);
      state_t s;
      s = T3;
      if (is_ralu(op) || is_ialu(op)) s = T5;
      else if (is_unary(op))          s = T4;
      else if (is_muldiv(op))         s = T6;
      else if (op == OP_LD)           s = T7;
      else if (op == OP_LDI)          s = T5;
      else if (op == OP_ST)           s = T7;
      else if (op == OP_BR)           s = T6;
      return s;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit to datapath signal bundle. The control unit is the master:
// it consumes IR/CON_FF/stop and drives every datapath strobe.
interface control_unit_if;

   logic [31:0]              IR;
   logic                     CON_FF;
   logic                     stop;

   logic                     run;
   logic                     Gra, Grb, Grc, Rin, Rout, BAout;
   logic                     PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout;
   logic                     PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
   logic                     outPort_in, CON_in;
   logic                     read, write;
   logic [cpu_pkg::ASELW-1:0] ALU_select;

   modport master (
      input  IR, CON_FF, stop,
      output run,
      output Gra, Grb, Grc, Rin, Rout, BAout,
      output PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout,
      output PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
      output outPort_in, CON_in,
      output read, write,
      output ALU_select
   );

   modport slave (
      output IR, CON_FF, stop,
      input  run,
      input  Gra, Grb, Grc, Rin, Rout, BAout,
      input  PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout,
      input  PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
      input  outPort_in, CON_in,
      input  read, write,
      input  ALU_select
   );

endinterface

// File: rtl/control_unit_op_to_alusel.sv
// Combinational map from opcode to the ALU operation it needs. Opcodes that
// do not use the ALU (and the address adds of ld/st/br) fall back to ADD.
module op_to_alusel
   import cpu_pkg::*;
(
   input  logic [OPW-1:0]   op,
   output logic [ASELW-1:0] alu_sel
);

   // Opcode to ALU operation lookup
   always_comb begin
      alu_sel = ALU_ADD;
      case (op)
         OP_ADD, OP_ADDI: alu_sel = ALU_ADD;
         OP_SUB:          alu_sel = ALU_SUB;
         OP_AND, OP_ANDI: alu_sel = ALU_AND;
         OP_OR,  OP_ORI:  alu_sel = ALU_OR;
         OP_SHR:          alu_sel = ALU_SHR;
         OP_SHRA:         alu_sel = ALU_SHRA;
         OP_SHL:          alu_sel = ALU_SHL;
         OP_ROR:          alu_sel = ALU_ROR;
         OP_ROL:          alu_sel = ALU_ROL;
         OP_MUL:          alu_sel = ALU_MUL;
         OP_DIV:          alu_sel = ALU_DIV;
         OP_NEG:          alu_sel = ALU_NEG;
         OP_NOT:          alu_sel = ALU_NOT;
         default:         alu_sel = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit. A microstep counter walks the shared
// fetch (T0-T2) and then the opcode's execute steps; strobes are a pure
// decode of the current step and opcode so that clr silences them at once.
module control_unit
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          clr,
   control_unit_if.master bus
);

   state_t            state_q, state_d;
   logic              stop_q, stop_d;
   logic [OPW-1:0]    op;
   logic [ASELW-1:0]  op_alu;
   logic [ASELW-1:0]  alu_sel;
   state_t            last;
   state_t            end_state;
   ctrl_t             ctl;

   assign op   = bus.IR[31:27];
   assign last = last_step(op);

   op_to_alusel u_alusel (
      .op      (op),
      .alu_sel (op_alu)
   );

   // Next microstep and sticky stop request
   always_comb begin
      stop_d    = stop_q | bus.stop;
      end_state = (op == OP_HALT || stop_d) ? S_HALT : T0;
      state_d   = state_q;
      case (state_q)
         S_RST:   state_d = T0;
         T0:      state_d = T1;
         T1:      state_d = T2;
         T2:      state_d = T3;
         T3:      state_d = (last == T3) ? end_state : T4;
         T4:      state_d = (last == T4) ? end_state : T5;
         T5:      state_d = (last == T5) ? end_state : T6;
         T6:      state_d = (last == T6) ? end_state : T7;
         T7:      state_d = end_state;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // State and stop latch, cleared asynchronously by clr
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_RST;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
      end
   end

   // Strobe decode for the current microstep and opcode
   always_comb begin
      ctl     = '0;
      alu_sel = ALU_ADD;
      ctl.run = (state_q != S_RST) && (state_q != S_HALT);
      case (state_q)
         T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; end
         T1: begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
         T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
         T3: begin
            if (is_ralu(op) || is_ialu(op)) begin
               ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.y_in = 1'b1;
            end else if (is_unary(op)) begin
               ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.z_in = 1'b1; alu_sel = op_alu;
            end else if (is_muldiv(op)) begin
               ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.y_in = 1'b1;
            end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
               ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
            end else if (op == OP_BR) begin
               ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.con_in = 1'b1;
            end else if (op == OP_JR) begin
               ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pc_in = 1'b1;
            end else if (op == OP_IN) begin
               ctl.in_port_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end else if (op == OP_OUT) begin
               ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.out_port_in = 1'b1;
            end else if (op == OP_MFHI) begin
               ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end else if (op == OP_MFLO) begin
               ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end
         end
         T4: begin
            if (is_ralu(op)) begin
               ctl.grc = 1'b1; ctl.rout = 1'b1; ctl.z_in = 1'b1; alu_sel = op_alu;
            end else if (is_ialu(op)) begin
               ctl.c_out = 1'b1; ctl.z_in = 1'b1; alu_sel = op_alu;
            end else if (is_unary(op)) begin
               ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end else if (is_muldiv(op)) begin
               ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.z_in = 1'b1; alu_sel = op_alu;
            end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
               ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            end else if (op == OP_BR) begin
               ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
            end
         end
         T5: begin
            if (is_ralu(op) || is_ialu(op) || op == OP_LDI) begin
               ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end else if (is_muldiv(op)) begin
               ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
            end else if (op == OP_LD || op == OP_ST) begin
               ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
            end else if (op == OP_BR) begin
               ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            end
         end
         T6: begin
            if (is_muldiv(op)) begin
               ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1;
            end else if (op == OP_LD) begin
               ctl.read = 1'b1; ctl.mdr_in = 1'b1;
            end else if (op == OP_ST) begin
               ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.mdr_in = 1'b1;
            end else if (op == OP_BR) begin
               // branch target is in Z; the CON result decides whether PC takes it
               ctl.zlow_out = 1'b1; ctl.pc_in = bus.CON_FF;
            end
         end
         T7: begin
            if (op == OP_LD) begin
               ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end else if (op == OP_ST) begin
               ctl.write = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.run        = ctl.run;
   assign bus.Gra        = ctl.gra;
   assign bus.Grb        = ctl.grb;
   assign bus.Grc        = ctl.grc;
   assign bus.Rin        = ctl.rin;
   assign bus.Rout       = ctl.rout;
   assign bus.BAout      = ctl.ba_out;
   assign bus.PCout      = ctl.pc_out;
   assign bus.ZLOWout    = ctl.zlow_out;
   assign bus.ZHIout     = ctl.zhi_out;
   assign bus.LOout      = ctl.lo_out;
   assign bus.HIout      = ctl.hi_out;
   assign bus.MDRout     = ctl.mdr_out;
   assign bus.inPortout  = ctl.in_port_out;
   assign bus.Cout       = ctl.c_out;
   assign bus.PC_in      = ctl.pc_in;
   assign bus.Inc_PC     = ctl.inc_pc;
   assign bus.IR_in      = ctl.ir_in;
   assign bus.Y_in       = ctl.y_in;
   assign bus.Z_in       = ctl.z_in;
   assign bus.HI_in      = ctl.hi_in;
   assign bus.LO_in      = ctl.lo_in;
   assign bus.MAR_in     = ctl.mar_in;
   assign bus.MDR_in     = ctl.mdr_in;
   assign bus.outPort_in = ctl.out_port_in;
   assign bus.CON_in     = ctl.con_in;
   assign bus.read       = ctl.read;
   assign bus.write      = ctl.write;
   assign bus.ALU_select = alu_sel;

endmodule
